// File: rtl/time_hhmm_counter_pkg.sv
// time_hhmm_counter_pkg: mode encodings and BCD limits shared by the minutes/hours stage
package time_hhmm_counter_pkg;
  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_SET_H = 2'b01;
  localparam logic [1:0] MODE_SET_M = 2'b10;
  localparam int BCD_UNITS_MAX = 9;
  localparam int MIN_TENS_MAX  = 5;
  localparam int HOUR_MAX_24   = 23;
  localparam int HOUR_MAX_12   = 12;
  localparam int HOUR_MIN_12   = 1;
endpackage

// File: rtl/time_hhmm_counter_if.sv
// time_hhmm_counter_if: carry/button inputs and BCD time/mode outputs of the minutes/hours stage
interface time_hhmm_counter_if;
  logic       carry_in;
  logic       set_btn;
  logic       inc_btn;
  logic [3:0] min_u;
  logic [2:0] min_t;
  logic [3:0] hour_u;
  logic [1:0] hour_t;
  logic [1:0] mode;
  logic       day_carry;
  modport master (output carry_in, set_btn, inc_btn,
                  input  min_u, min_t, hour_u, hour_t, mode, day_carry);
  modport slave  (input  carry_in, set_btn, inc_btn,
                  output min_u, min_t, hour_u, hour_t, mode, day_carry);
endinterface

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter that wraps from MAX to WRAP on inc, flagging the wrap
module bcd_mod_counter
  import time_hhmm_counter_pkg::*;
#(
  parameter int TW         = 3,
  parameter int MAX_TENS   = 5,
  parameter int MAX_UNITS  = 9,
  parameter int WRAP_TENS  = 0,
  parameter int WRAP_UNITS = 0,
  parameter int RST_TENS   = 0,
  parameter int RST_UNITS  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [TW-1:0] tens,
  output logic [3:0]    units,
  output logic          wrap
);
  logic [TW-1:0] tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic          at_max, units_top;
  always_comb begin
    at_max    = tens_q == TW'(MAX_TENS) && units_q == 4'(MAX_UNITS);
    units_top = units_q == 4'(BCD_UNITS_MAX);
    wrap      = inc & at_max;
    tens_d    = !inc ? tens_q : at_max ? TW'(WRAP_TENS) : units_top ? tens_q + TW'(1) : tens_q;
    units_d   = !inc ? units_q : at_max ? 4'(WRAP_UNITS) : units_top ? 4'd0 : units_q + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= TW'(RST_TENS);
      units_q <= 4'(RST_UNITS);
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end
  assign tens  = tens_q;
  assign units = units_q;
endmodule

// File: rtl/time_hhmm_counter.sv
// time_hhmm_counter: BCD minutes/hours driven by upstream minute carry, with hour/minute set mode
module time_hhmm_counter
  import time_hhmm_counter_pkg::*;
#(
  parameter int HOURS_24 = 1
) (
  input logic                 clk,
  input logic                 Reset_n,
  time_hhmm_counter_if.slave  bus
);
  localparam int HMAX  = HOURS_24 != 0 ? HOUR_MAX_24 : HOUR_MAX_12;
  localparam int HWRAP = HOURS_24 != 0 ? 0 : HOUR_MIN_12;
  localparam int HRST  = HOURS_24 != 0 ? 0 : HOUR_MAX_12;
  logic       carry_q, carry_d;
  logic [1:0] mode_q, mode_d;
  logic       day_carry_q, day_carry_d;
  logic       tick, run_tick, set_inc, min_inc, hour_inc, min_wrap, hour_wrap;
  // set_btn wins over both a tick and inc_btn in the same cycle
  assign tick     = bus.carry_in & ~carry_q;
  assign run_tick = tick & ~bus.set_btn & (mode_q == MODE_RUN);
  assign set_inc  = bus.inc_btn & ~bus.set_btn;
  assign min_inc  = run_tick | (set_inc & (mode_q == MODE_SET_M));
  assign hour_inc = (run_tick & min_wrap) | (set_inc & (mode_q == MODE_SET_H));
  always_comb begin
    carry_d     = bus.carry_in;
    day_carry_d = run_tick & hour_wrap;
    mode_d      = !bus.set_btn ? mode_q :
                  mode_q == MODE_RUN ? MODE_SET_H :
                  mode_q == MODE_SET_H ? MODE_SET_M : MODE_RUN;
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      carry_q     <= 1'b0;
      mode_q      <= MODE_RUN;
      day_carry_q <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      day_carry_q <= day_carry_d;
    end
  end
  bcd_mod_counter #(
    .TW(3), .MAX_TENS(MIN_TENS_MAX), .MAX_UNITS(BCD_UNITS_MAX),
    .WRAP_TENS(0), .WRAP_UNITS(0), .RST_TENS(0), .RST_UNITS(0)
  ) u_min (
    .clk(clk), .rst_n(Reset_n), .inc(min_inc),
    .tens(bus.min_t), .units(bus.min_u), .wrap(min_wrap)
  );
  bcd_mod_counter #(
    .TW(2), .MAX_TENS(HMAX / 10), .MAX_UNITS(HMAX % 10),
    .WRAP_TENS(HWRAP / 10), .WRAP_UNITS(HWRAP % 10),
    .RST_TENS(HRST / 10), .RST_UNITS(HRST % 10)
  ) u_hour (
    .clk(clk), .rst_n(Reset_n), .inc(hour_inc),
    .tens(bus.hour_t), .units(bus.hour_u), .wrap(hour_wrap)
  );
  assign bus.mode      = mode_q;
  assign bus.day_carry = day_carry_q;
endmodule

// File: tb/tb_time_hhmm_counter.sv
// tb_time_hhmm_counter: directed and random checks of 24h and 12h instances against a time-of-day model
module tb_time_hhmm_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic carry [2];
  logic setb  [2];
  logic incb  [2];
  int mh [2], mm [2], mmode [2], mdc [2], mprev [2];
  int total = 0;
  int bad = 0;
  logic [7:0] o_mu [2], o_mt [2], o_hu [2], o_ht [2], o_md [2], o_dc [2];

  always #5 clk = ~clk;

  time_hhmm_counter_if if0 ();
  time_hhmm_counter_if if1 ();

  assign if0.carry_in = carry[0];
  assign if0.set_btn  = setb[0];
  assign if0.inc_btn  = incb[0];
  assign if1.carry_in = carry[1];
  assign if1.set_btn  = setb[1];
  assign if1.inc_btn  = incb[1];
  assign o_mu[0] = 8'(if0.min_u);
  assign o_mt[0] = 8'(if0.min_t);
  assign o_hu[0] = 8'(if0.hour_u);
  assign o_ht[0] = 8'(if0.hour_t);
  assign o_md[0] = 8'(if0.mode);
  assign o_dc[0] = 8'(if0.day_carry);
  assign o_mu[1] = 8'(if1.min_u);
  assign o_mt[1] = 8'(if1.min_t);
  assign o_hu[1] = 8'(if1.hour_u);
  assign o_ht[1] = 8'(if1.hour_t);
  assign o_md[1] = 8'(if1.mode);
  assign o_dc[1] = 8'(if1.day_carry);

  time_hhmm_counter #(.HOURS_24(1)) dut24 (.clk(clk), .Reset_n(rst_n), .bus(if0));
  time_hhmm_counter #(.HOURS_24(0)) dut12 (.clk(clk), .Reset_n(rst_n), .bus(if1));

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = (k == 0) ? 0 : 12;
      mm[k] = 0;
      mmode[k] = 0;
      mdc[k] = 0;
      mprev[k] = 0;
    end
  endtask

  function automatic bit hadv(int k);
    if (k == 0) begin
      mh[k] = (mh[k] + 1) % 24;
      return mh[k] == 0;
    end
    mh[k] = mh[k] % 12 + 1;
    return mh[k] == 1;
  endfunction

  task automatic mstep(int k);
    bit tick;
    tick = carry[k] && (mprev[k] == 0);
    mprev[k] = int'(carry[k]);
    mdc[k] = 0;
    if (setb[k]) mmode[k] = (mmode[k] + 1) % 3;
    else if (mmode[k] == 0 && tick) begin
      mm[k]++;
      if (mm[k] == 60) begin
        mm[k] = 0;
        mdc[k] = int'(hadv(k));
      end
    end
    else if (mmode[k] == 1 && incb[k]) void'(hadv(k));
    else if (mmode[k] == 2 && incb[k]) mm[k] = (mm[k] + 1) % 60;
  endtask

  task automatic chk(string tag, int k, logic [7:0] obs, int exp);
    total++;
    assert (obs === 8'(exp)) else begin
      bad++;
      $error("FAIL %s dut%0d got=%0d want=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(int k);
    chk("min_u", k, o_mu[k], mm[k] % 10);
    chk("min_t", k, o_mt[k], mm[k] / 10);
    chk("hour_u", k, o_hu[k], mh[k] % 10);
    chk("hour_t", k, o_ht[k], mh[k] / 10);
    chk("mode", k, o_md[k], mmode[k]);
    chk("day_carry", k, o_dc[k], mdc[k]);
  endtask

  task automatic expect_t(int k, int h, int m, int md, int dc);
    chk("exp_hour_t", k, o_ht[k], h / 10);
    chk("exp_hour_u", k, o_hu[k], h % 10);
    chk("exp_min_t", k, o_mt[k], m / 10);
    chk("exp_min_u", k, o_mu[k], m % 10);
    chk("exp_mode", k, o_md[k], md);
    chk("exp_day_carry", k, o_dc[k], dc);
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk_all(0);
    chk_all(1);
  endtask

  task automatic press_set(int k);
    setb[k] = 1'b1;
    cyc();
    setb[k] = 1'b0;
  endtask

  task automatic press_inc(int k);
    incb[k] = 1'b1;
    cyc();
    incb[k] = 1'b0;
  endtask

  task automatic set_time(int k, int h, int m);
    press_set(k);
    while (mh[k] != h) press_inc(k);
    press_set(k);
    while (mm[k] != m) press_inc(k);
    press_set(k);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk_all(0);
    chk_all(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      carry[k] = 1'b0;
      setb[k] = 1'b0;
      incb[k] = 1'b0;
    end
    mreset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_all(0);
    chk_all(1);
    expect_t(0, 0, 0, 0, 0);
    expect_t(1, 12, 0, 0, 0);

    // reset in SET_M at 13:47
    set_time(0, 13, 47);
    press_set(0);
    press_set(0);
    expect_t(0, 13, 47, 2, 0);
    async_reset();
    expect_t(0, 0, 0, 0, 0);
    expect_t(1, 12, 0, 0, 0);

    // 24h day wrap with carry held high
    set_time(0, 23, 59);
    expect_t(0, 23, 59, 0, 0);
    carry[0] = 1'b1;
    cyc();
    expect_t(0, 0, 0, 0, 1);
    repeat (19) cyc();
    expect_t(0, 0, 0, 0, 0);
    carry[0] = 1'b0;
    cyc();

    // 12h: 11:59 -> 12:00 without carry, 12:59 -> 01:00 with carry
    set_time(1, 11, 59);
    carry[1] = 1'b1;
    cyc();
    expect_t(1, 12, 0, 0, 0);
    carry[1] = 1'b0;
    cyc();
    set_time(1, 12, 59);
    carry[1] = 1'b1;
    cyc();
    expect_t(1, 1, 0, 0, 1);
    carry[1] = 1'b0;
    cyc();
    expect_t(1, 1, 0, 0, 0);

    // set mode editing
    set_time(0, 22, 10);
    press_set(0);
    repeat (5) press_inc(0);
    expect_t(0, 3, 10, 1, 0);
    press_set(0);
    while (mm[0] != 58) press_inc(0);
    expect_t(0, 3, 58, 2, 0);
    repeat (3) press_inc(0);
    expect_t(0, 3, 1, 2, 0);
    press_set(0);
    expect_t(0, 3, 1, 0, 0);

    // tick dropped in SET_H, level carry does not count after returning to RUN
    press_set(0);
    carry[0] = 1'b1;
    cyc();
    expect_t(0, 3, 1, 1, 0);
    press_set(0);
    press_set(0);
    cyc();
    expect_t(0, 3, 1, 0, 0);
    carry[0] = 1'b0;
    cyc();
    carry[0] = 1'b1;
    cyc();
    expect_t(0, 3, 2, 0, 0);
    carry[0] = 1'b0;
    cyc();

    // simultaneous set/inc and set/tick
    press_set(0);
    setb[0] = 1'b1;
    incb[0] = 1'b1;
    cyc();
    setb[0] = 1'b0;
    incb[0] = 1'b0;
    expect_t(0, 3, 2, 2, 0);
    press_set(0);
    set_time(0, 8, 15);
    carry[0] = 1'b1;
    setb[0] = 1'b1;
    cyc();
    setb[0] = 1'b0;
    expect_t(0, 8, 15, 1, 0);
    carry[0] = 1'b0;
    press_set(0);
    press_set(0);
    expect_t(0, 8, 15, 0, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(3) == 0) carry[k] = ~carry[k];
        setb[k] = ($urandom_range(29) == 0);
        incb[k] = ($urandom_range(2) == 0);
      end
      cyc();
      if (i == 2000) async_reset();
    end
    for (int k = 0; k < 2; k++) begin
      setb[k] = 1'b0;
      incb[k] = 1'b0;
    end
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
